fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ requesters onto one FIFO write port.
// Optional stall/beat counters are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          w_clk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          wr_req,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          grant_active
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]                   stall_cnt,
    output logic [15:0]                   beat_total
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [IW-1:0]   sel;
    logic            found;
    logic [SW-1:0]   sum;
    logic [IW-1:0]   idx;
    logic            g_valid;
    logic            g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic            accept;

    // First valid requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + SW'(k);
            if (sum >= SW'(NUM_REQ))
                sum = sum - SW'(NUM_REQ);
            idx = sum[IW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept = (state_q == BURST) && g_valid && !fifo_full;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = '0;
        wr_req     = 1'b0;
        data_in    = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = sel;
                    rr_ptr_d   = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id_q] = !fifo_full;
                wr_req  = accept;
                data_in = accept ? g_data : '0;
                if (accept)
                    beat_cnt_d = beat_cnt_q + 1'b1;
                // A full FIFO freezes the burst; an idle requester only ends it when not full.
                if (accept && (g_last || beat_cnt_q == BW'(MAX_BURST - 1)))
                    state_d = IDLE;
                else if (!g_valid && !fifo_full)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_id     = grant_id_q;
    assign grant_active = (state_q == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt_q, beat_total_q;

    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) begin
            stall_cnt_q  <= '0;
            beat_total_q <= '0;
        end else begin
            if (state_q == BURST && fifo_full && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (wr_req && beat_total_q != 16'hFFFF)
                beat_total_q <= beat_total_q + 16'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign beat_total = beat_total_q;
`endif

endmodule
